seq_booth_mult: RTL and testbench
=================================

# seq_booth_mult

Parametrised multi-cycle multiplier for the arithmetic unit. It computes an unsigned or two's-complement signed product of two WIDTH-bit operands with radix-2 Booth recoding, one iteration per clock. The interface is a start/busy/done handshake. It replaces the combinational array multiplier where area matters more than latency, and serves as the datapath multiplier for the lab processor's MUL instruction.

## Interface
- WIDTH, 6, operand width in bits; legal range 2..32; product is 2*WIDTH bits
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- a  input  WIDTH  multiplicand; latched on accepted start
- b  input  WIDTH  multiplier; latched on accepted start
- busy  output  1  high in RUN and DONE; start ignored while high
- done  output  1  one-cycle pulse, high exactly in DONE
- product  output  2*WIDTH  result; holds last result until the next result is written

## Operation
- Reset (async, active-high): state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE when the iteration counter reaches WIDTH.
  - DONE -> IDLE unconditionally.
- Load at accepted start:
  - Operands are extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - M = ext(a), Q = ext(b), A = 0, q_m1 = 0, count = 0.
- RUN iteration, per clock, on {Q[0], q_m1}:
  - 01: A = A + M
  - 10: A = A - M
  - 00/11: no change
  - Then arithmetic right shift of {A,Q,q_m1} by one, with A being WIDTH+1 bits. Then count++.
- WIDTH+1 iterations in total, with count going 0..WIDTH.
- On the final iteration, product is written with the low 2*WIDTH bits of the shifted {A,Q}.
- Width rules:
  - The A add/sub is WIDTH+1 bits, and overflow is discarded.
  - Extension by one bit makes unsigned and signed share one datapath.
  - Unsigned max (2^W-1)^2 and signed min*min (2^(2W-2)) both fit in 2*WIDTH bits exactly.
- product changes only on the final-iteration edge. Between results it is stable, including during RUN of a new operation.
- Changes to a, b or signed_mode after acceptance have no effect on the operation in progress.

## Timing
- The start edge (call it edge 0) loads the operands.
- Iterations occur on edges 1..WIDTH+1.
- done=1 during the cycle following edge WIDTH+1, i.e. latency WIDTH+1 cycles from the accepting edge. For WIDTH=6 this is 7.
- Throughput: one result per WIDTH+3 cycles.
  - start held continuously high is accepted again on the edge where DONE->IDLE has completed, i.e. the first IDLE cycle.
  - No start is accepted in DONE.
- start while busy=1: ignored, not queued, no effect on state or product.
- rst asserted mid-RUN or in DONE:
  - Immediate return to IDLE with outputs at reset values.
  - product is cleared to 0.
  - No done pulse is emitted for the aborted operation.
- The start/rst release edge is not special-cased: start is sampled on the first clock edge with rst=0.

## Structure
- Shared package mult_pkg:
  - state enum {IDLE, RUN, DONE}
  - function cnt_w(WIDTH) = $clog2(WIDTH+2) for the iteration counter
  - Booth opcode constants for {Q[0], q_m1}
- One combinational sub-module, booth_step, parametrised by WIDTH:
  - Inputs: A, Q, q_m1, M.
  - Outputs: next A, Q, q_m1 (add/sub plus arithmetic shift).
- The top holds the FSM, the counter, the operand and product registers, and instantiates booth_step once.

## Test plan
WIDTH=6 unless noted.
- Unsigned corners:
  - 63*63 -> product=3969, done high exactly 7 cycles after the start edge, one cycle wide.
  - 0*63 -> 0.
  - 12*24 -> 288.
- Signed:
  - a=6'b111111 (-1), b=7 -> 12'hFF9 (-7).
  - a=-32, b=-32 -> 1024.
  - a=-32, b=31 -> 12'hC20 (-992).
  - Same bit patterns with signed_mode=0 -> 63*7=441, 32*32=1024, 32*31=992.
- Start while busy:
  - Second start with a=5, b=5 pulsed at cycles 2 and 6 of a 49*44 operation -> ignored.
  - product=2156 once, busy stays high, no extra done.
- Reset mid-operation:
  - rst pulsed at cycle 3 of 60*6 -> busy=0, done=0, product=0 asynchronously.
  - Next start 19*19 -> 361 with normal latency.
- Back-to-back:
  - start held high with a,b changing each cycle -> each accepted pair comes from its accepting IDLE cycle.
  - Results are spaced 9 cycles apart.
  - product holds between done pulses.
- Random sweep:
  - 1000 random a, b, signed_mode at WIDTH=6, 8 and 16, checked against the reference product.
  - WIDTH=2 exhaustive in both modes.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth opcodes on {q[0], q_m1}
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  // Counter must hold WIDTH, and WIDTH+1 after the final increment
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of m into acc, then
// arithmetic right shift of {acc, q, q_m1} by one bit.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH:0] acc,
  input  logic [WIDTH:0] q,
  input  logic           q_m1,
  input  logic [WIDTH:0] m,
  output logic [WIDTH:0] acc_nxt,
  output logic [WIDTH:0] q_nxt,
  output logic           q_m1_nxt
);

  logic [WIDTH:0] sum;

  // add/sub wraps at WIDTH+1 bits; the shift replicates the sign of sum
  always_comb begin
    case ({q[0], q_m1})
      OP_ADD:  sum = acc + m;
      OP_SUB:  sum = acc - m;
      default: sum = acc;
    endcase
    {acc_nxt, q_nxt, q_m1_nxt} = {sum[WIDTH], sum, q};
  end

endmodule

// File: rtl/seq_booth_mult.sv
// Multi-cycle signed/unsigned multiplier, one Booth iteration per clock.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on accepted start
//   RUN   | WIDTH+1 Booth iterations, count 0..WIDTH
//   DONE  | one-cycle done pulse; product valid
module seq_booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  state_t          state, state_nxt;
  logic [WIDTH:0]  m_r, acc_r, q_r;
  logic            q_m1_r;
  logic [CW-1:0]   cnt_r;
  logic [WIDTH:0]  acc_nxt, q_nxt;
  logic            q_m1_nxt;
  logic            load, last_iter;

  assign load      = (state == IDLE) && start;
  assign last_iter = (state == RUN) && (cnt_r == LAST);

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .q        (q_r),
    .q_m1     (q_m1_r),
    .m        (m_r),
    .acc_nxt  (acc_nxt),
    .q_nxt    (q_nxt),
    .q_m1_nxt (q_m1_nxt)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt_r == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // operand load, iteration registers and product capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r     <= '0;
      acc_r   <= '0;
      q_r     <= '0;
      q_m1_r  <= 1'b0;
      cnt_r   <= '0;
      product <= '0;
    end else if (load) begin
      // one extra bit lets unsigned and signed share the signed datapath
      m_r    <= {signed_mode & a[WIDTH-1], a};
      q_r    <= {signed_mode & b[WIDTH-1], b};
      acc_r  <= '0;
      q_m1_r <= 1'b0;
      cnt_r  <= '0;
    end else if (state == RUN) begin
      acc_r  <= acc_nxt;
      q_r    <= q_nxt;
      q_m1_r <= q_m1_nxt;
      cnt_r  <= cnt_r + 1'b1;
      if (last_iter) product <= {acc_nxt[WIDTH-2:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
module tb_seq_booth_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_sw = 1'b1;
  logic        start = 1'b0;
  logic        sm = 1'b0;
  logic [5:0]  a = '0;
  logic [5:0]  b = '0;
  logic        busy, done;
  logic [11:0] product;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seq_booth_mult #(.WIDTH(6)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (sm),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: interpret operands per mode, multiply as integers, keep 2w bits
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x,
                                          input logic [63:0] y, input bit s);
    longint sx, sy, p;
    logic [63:0] msk;
    sx = longint'(x);
    sy = longint'(y);
    if (s && x[w-1]) sx = sx - (longint'(1) << w);
    if (s && y[w-1]) sy = sy - (longint'(1) << w);
    p   = sx * sy;
    msk = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & msk;
  endfunction

  // start one operation from an IDLE negedge, check latency, result and pulse width
  task automatic do_op(input logic [5:0] ta, input logic [5:0] tb_, input bit ts,
                       input logic [63:0] exp, input string tag);
    int k;
    a = ta; b = tb_; sm = ts; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 6'($urandom); b = 6'($urandom); sm = 1'($urandom);
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    chk({tag, "_lat"}, 64'(k), 64'd7);
    chk(tag, 64'(product), exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
  endtask

  // wider / narrower instances run their sweeps concurrently
  for (genvar g = 0; g < 3; g++) begin : gsw
    localparam int WS   = (g == 0) ? 8 : (g == 1) ? 16 : 2;
    localparam int NOPS = (WS == 2) ? 32 : 1000;
    logic            st = 1'b0, s_m = 1'b0;
    logic [WS-1:0]   xa = '0, xb = '0;
    logic            bz, dn;
    logic [2*WS-1:0] pr;
    bit              fin_g = 1'b0;

    seq_booth_mult #(.WIDTH(WS)) u_dut (
      .clk         (clk),
      .rst         (rst_sw),
      .start       (st),
      .signed_mode (s_m),
      .a           (xa),
      .b           (xb),
      .busy        (bz),
      .done        (dn),
      .product     (pr)
    );

    initial begin
      int k;
      logic [31:0] ra, rb;
      bit rs;
      logic [63:0] e;
      @(negedge rst_sw);
      for (int i = 0; i < NOPS; i++) begin
        @(negedge clk);
        ra = (WS == 2) ? 32'(i & 3) : $urandom;
        rb = (WS == 2) ? 32'((i >> 2) & 3) : $urandom;
        rs = (WS == 2) ? ((i >> 4) & 1) != 0 : $urandom_range(1, 0) != 0;
        xa = ra[WS-1:0];
        xb = rb[WS-1:0];
        s_m = rs;
        e = ref_mul(WS, 64'(xa), 64'(xb), rs);
        st = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st = 1'b0;
        for (k = 1; k <= 2 * WS + 8; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (dn) break;
        end
        chk($sformatf("w%0d_lat", WS), 64'(k), 64'(WS + 1));
        chk($sformatf("w%0d_prod a=%0h b=%0h s=%0d", WS, xa, xb, rs), 64'(pr), e);
      end
      fin_g = 1'b1;
    end
  end

  logic [5:0]  da [9] = '{6'd63, 6'd0, 6'd12, 6'd63, 6'd32, 6'd32, 6'd63, 6'd32, 6'd32};
  logic [5:0]  db [9] = '{6'd63, 6'd63, 6'd24, 6'd7, 6'd32, 6'd31, 6'd7, 6'd32, 6'd31};
  bit          dsm[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
  logic [11:0] dex[9] = '{12'd3969, 12'd0, 12'd288, 12'hFF9, 12'd1024, 12'hC20,
                          12'd441, 12'd1024, 12'd992};

  initial begin
    int nd, at, k;
    bit bz_ok;
    logic [5:0] pa [28], pb [28];
    bit ps [28];
    logic [63:0] held;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("reset_state", {50'd0, busy, done, product}, 64'd0);
    rst = 1'b0;
    rst_sw = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_op(da[i], db[i], dsm[i], 64'(dex[i]), $sformatf("dir%0d", i));

    // start pulses while busy must be ignored
    a = 6'd49; b = 6'd44; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nd = 0; at = 0; bz_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin nd++; at = k; end
      if (k <= 7 && !busy) bz_ok = 1'b0;
      start = (k == 2 || k == 6);
      if (start) begin a = 6'd5; b = 6'd5; end
    end
    start = 1'b0;
    chk("busy_ndone", 64'(nd), 64'd1);
    chk("busy_done_at", 64'(at), 64'd7);
    chk("busy_held", 64'(bz_ok), 64'd1);
    chk("busy_prod", 64'(product), 64'd2156);

    // asynchronous abort mid-run
    a = 6'd60; b = 6'd6; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", {50'd0, busy, done, product}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    do_op(6'd19, 6'd19, 1'b0, 64'd361, "post_abort");

    // back-to-back with start held high; pairs accepted at edges 0, 9, 18, 27
    held = 64'd361;
    for (int i = 0; i < 28; i++) begin
      pa[i] = 6'($urandom); pb[i] = 6'($urandom); ps[i] = 1'($urandom);
    end
    for (int i = 0; i < 28; i++) begin
      a = pa[i]; b = pb[i]; sm = ps[i]; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (i % 9 == 7) held = ref_mul(6, 64'(pa[i-7]), 64'(pb[i-7]), ps[i-7]);
      chk($sformatf("b2b_done c%0d", i), 64'(done), 64'(i % 9 == 7));
      chk($sformatf("b2b_prod c%0d", i), 64'(product), held);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      do_op(ra[5:0], rb[5:0], ra[31],
            ref_mul(6, 64'(ra[5:0]), 64'(rb[5:0]), ra[31]), "w6_rand");
    end

    for (k = 0; k < 60000; k++) begin
      if (gsw[0].fin_g && gsw[1].fin_g && gsw[2].fin_g) break;
      @(negedge clk);
    end
    chk("sweeps_finished", {61'd0, gsw[2].fin_g, gsw[1].fin_g, gsw[0].fin_g}, 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
